// File: rtl/regfile_write_arbiter_if.sv
// Bundle between the datapath and the register-file write arbiter:
// WB and MD write requests in, register-file write port and hazard info out.
interface regfile_write_arbiter_if #(
    parameter int REG_SELECT_WIDTH = 5,
    parameter int DATA_WIDTH       = 32
);
    // WB has no ready: a WbValid is either granted this cycle or dropped (select 0),
    // unless WbStall is high, in which case upstream holds it. An MD result transfers
    // on a posedge where MdValid && MdReady; MdValid/MdSelect/MdData stay stable until then.
    logic                              WbValid;
    logic [REG_SELECT_WIDTH-1:0]       WbSelect;
    logic [DATA_WIDTH-1:0]             WbData;
    logic                              WbStall;
    logic                              MdValid;
    logic                              MdReady;
    logic [REG_SELECT_WIDTH-1:0]       MdSelect;
    logic [DATA_WIDTH-1:0]             MdData;
    logic                              WriteEnable;
    logic [REG_SELECT_WIDTH-1:0]       WriteSelect;
    logic [DATA_WIDTH-1:0]             WriteData;
    logic [(1<<REG_SELECT_WIDTH)-1:0]  PendingMask;

    modport master (
        output WbValid, WbSelect, WbData, MdValid, MdSelect, MdData,
        input  WbStall, MdReady, WriteEnable, WriteSelect, WriteData, PendingMask
    );

    modport slave (
        input  WbValid, WbSelect, WbData, MdValid, MdSelect, MdData,
        output WbStall, MdReady, WriteEnable, WriteSelect, WriteData, PendingMask
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between WB (priority) and a small MD result FIFO.
// Define REGFILE_ARB_STARVE_EN to enable the starvation guard that forces a one-cycle WB stall.
module regfile_write_arbiter #(
    parameter int REG_SELECT_WIDTH = 5,
    parameter int DATA_WIDTH       = 32,
    parameter int FIFO_DEPTH_LOG2  = 1,
    parameter int STARVE_LIMIT     = 4
) (
    input logic                    Clk,
    input logic                    Reset,
    regfile_write_arbiter_if.slave bus
);
    localparam int DEPTH    = 1 << FIFO_DEPTH_LOG2;
    localparam int NUM_REGS = 1 << REG_SELECT_WIDTH;
    localparam logic [FIFO_DEPTH_LOG2:0]   COUNT_ONE = 1;
    localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE   = 1;

    logic [REG_SELECT_WIDTH-1:0] fifo_sel  [DEPTH];
    logic [DATA_WIDTH-1:0]       fifo_data [DEPTH];
    logic [DEPTH-1:0]            fifo_live;
    logic [DEPTH-1:0]            live_next;
    logic [FIFO_DEPTH_LOG2-1:0]  wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0]  rd_ptr;
    logic [FIFO_DEPTH_LOG2:0]    count;
    logic [FIFO_DEPTH_LOG2:0]    count_next;
    logic [NUM_REGS-1:0]         pending_mask;
    logic [NUM_REGS-1:0]         mask_next;

    logic                        write_enable;
    logic [REG_SELECT_WIDTH-1:0] write_select;
    logic [DATA_WIDTH-1:0]       write_data;

    logic full;
    logic empty;
    logic head_live;
    logic md_ready;
    logic push;
    logic wb_grant;
    logic pop;
    logic md_grant;
    logic stall;

    // Count only reaches DEPTH when full, so its top bit is the full flag.
    always_comb begin
        full      = count[FIFO_DEPTH_LOG2];
        empty     = (count == '0);
        head_live = !empty && fifo_live[rd_ptr];
        md_ready  = !full;
        push      = bus.MdValid && md_ready && (bus.MdSelect != '0);
        wb_grant  = bus.WbValid && !stall && (bus.WbSelect != '0);
        pop       = !wb_grant && !empty;
        md_grant  = pop && head_live;
    end

    // Kill before push: an entry pushed alongside a WB write to the same register is younger.
    always_comb begin
        live_next = fifo_live;
        if (pop) begin
            live_next[rd_ptr] = 1'b0;
        end
        if (wb_grant) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (fifo_sel[i] == bus.WbSelect) begin
                    live_next[i] = 1'b0;
                end
            end
        end
        if (push) begin
            live_next[wr_ptr] = 1'b1;
        end
    end

    always_comb begin
        mask_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_next[i]) begin
                if (push && (FIFO_DEPTH_LOG2'(i) == wr_ptr)) begin
                    mask_next[bus.MdSelect] = 1'b1;
                end else begin
                    mask_next[fifo_sel[i]] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + COUNT_ONE;
            2'b01:   count_next = count - COUNT_ONE;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (push) begin
            fifo_sel[wr_ptr]  <= bus.MdSelect;
            fifo_data[wr_ptr] <= bus.MdData;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            fifo_live    <= '0;
            pending_mask <= '0;
            write_enable <= 1'b0;
            write_select <= '0;
            write_data   <= '0;
        end else begin
            count        <= count_next;
            fifo_live    <= live_next;
            pending_mask <= mask_next;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            write_enable <= wb_grant || md_grant;
            if (wb_grant) begin
                write_select <= bus.WbSelect;
                write_data   <= bus.WbData;
            end else if (md_grant) begin
                write_select <= fifo_sel[rd_ptr];
                write_data   <= fifo_data[rd_ptr];
            end
        end
    end

`ifdef REGFILE_ARB_STARVE_EN
    localparam int STARVE_WIDTH = $clog2(STARVE_LIMIT + 1);

    logic [STARVE_WIDTH-1:0] starve_cnt;
    logic [STARVE_WIDTH-1:0] starve_next;

    // A stall cycle always pops the live head, so the counter never passes the limit.
    always_comb begin
        starve_next = starve_cnt;
        if (pop || empty) begin
            starve_next = '0;
        end else if (head_live) begin
            starve_next = starve_cnt + STARVE_WIDTH'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            starve_cnt <= '0;
            stall      <= 1'b0;
        end else begin
            starve_cnt <= starve_next;
            stall      <= (starve_next == STARVE_WIDTH'(STARVE_LIMIT));
        end
    end
`else
    assign stall = 1'b0;
`endif

    assign bus.MdReady     = md_ready;
    assign bus.WbStall     = stall;
    assign bus.WriteEnable = write_enable;
    assign bus.WriteSelect = write_select;
    assign bus.WriteData   = write_data;
    assign bus.PendingMask = pending_mask;

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single write port of the pipelined datapath's register file between two requesters: the writeback (WB) stage and the multi-cycle multiply/divide (MD) unit.
- WB writes have priority and have no ready signal. MD results are buffered in a small FIFO and drained on cycles when WB is idle.
- A pending-register mask feeds the hazard unit.
- Optional starvation guard forces a WB stall so that MD results cannot wait indefinitely.

Parameters:
- REG_SELECT_WIDTH, 5: register select width; the register file holds 2**REG_SELECT_WIDTH registers.
- DATA_WIDTH, 32: register data width.
- FIFO_DEPTH_LOG2, 1: the MD buffer holds 2**FIFO_DEPTH_LOG2 entries (default 2).
- STARVE_LIMIT, 4: consecutive blocked cycles of the FIFO head before a forced stall (optional feature only).

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Reset  in  1  synchronous, active-low reset.
- WbValid  in  1  WB write request this cycle.
- WbSelect  in  REG_SELECT_WIDTH  WB destination register.
- WbData  in  DATA_WIDTH  WB write data.
- MdValid  in  1  MD result available.
- MdReady  out  1  arbiter can accept an MD result.
- MdSelect  in  REG_SELECT_WIDTH  MD destination register.
- MdData  in  DATA_WIDTH  MD result data.
- WriteEnable  out  1  to register file WriteEnable.
- WriteSelect  out  REG_SELECT_WIDTH  to register file WriteSelect.
- WriteData  out  DATA_WIDTH  to register file WriteData.
- PendingMask  out  2**REG_SELECT_WIDTH  bit r=1 while a live FIFO entry targets register r.
- WbStall  out  1  forced WB stall; upstream must hold its WB request (optional feature).

Behaviour:
- Reset (Reset==0 at posedge):
  - WriteEnable=0, WriteSelect=0, WriteData=0.
  - FIFO emptied; all entries dead; PendingMask=0.
  - Starve counter=0; WbStall=0.
  - MdReady=1 in the first cycle after reset.
  - Reset mid-operation discards queued MD results without writing them.
- MD push handshake:
  - MdReady = !full, combinational from the registered count.
  - Push occurs when MdValid && MdReady at posedge.
  - When full, no push even if a pop happens the same cycle.
  - A push with MdSelect==0 is accepted and discarded: no entry, no PendingMask bit.
- Arbitration (per cycle, decided combinationally, registered to the outputs):
  1. If WbValid && !WbStall && WbSelect!=0: grant WB.
  2. Else if the FIFO head is live: grant the head and pop it.
  3. Else if the FIFO head is dead (killed): pop it silently, no write.
  4. Else: no write.
  - A WbValid with WbSelect==0 is dropped, and the FIFO may drain that cycle.
- Output latency:
  - The granted write appears on WriteEnable/WriteSelect/WriteData in the cycle after the request is sampled: 1-cycle latency.
  - The register file commits the write at the following posedge.
  - When no write is granted, WriteEnable=0 and WriteSelect/WriteData hold their last values.
- Write-after-write kill:
  - A granted WB write to register r kills every live FIFO entry with select r.
  - Killed entries stay in the FIFO until popped, are never written, and clear their PendingMask bit in the cycle after the kill.
- Simultaneous push and kill:
  - An MD entry pushed in the same cycle as a WB write to the same register is NOT killed. The MD result is younger.
- Simultaneous push and pop: allowed when not full; the count is unchanged.
- PendingMask: OR over live FIFO entries, registered. A bit clears in the cycle after that entry's pop or kill.
- Pointers wrap modulo 2**FIFO_DEPTH_LOG2; the count is FIFO_DEPTH_LOG2+1 bits wide.

Optional Feature:
- Macro: REGFILE_ARB_STARVE_EN.
- When defined:
  - A counter increments each cycle the FIFO head is live but not granted.
  - The counter resets to 0 on any pop, or when the FIFO is empty.
  - When the counter reaches STARVE_LIMIT, WbStall=1 (registered) for exactly one cycle. During that cycle the head is granted and the counter returns to 0.
  - WB input is ignored while WbStall=1.
- When undefined: WbStall is tied to 0, no counter exists, and MD can starve indefinitely.

Test Plan:
- Reset low 2 cycles, then high:
  - Expect WriteEnable=0, MdReady=1, PendingMask=0.
  - Then WbValid=1, WbSelect=5, WbData=0xA5A5A5A5 -> next cycle WriteEnable=1, WriteSelect=5, WriteData=0xA5A5A5A5.
- Push MD (sel 7, 0x11) while WbValid is continuously high to sel 3:
  - With the macro undefined: PendingMask[7]=1 and no MD write while WB is busy.
  - Drop WbValid -> the next cycle writes sel 7 with 0x11, and PendingMask[7] clears one cycle after the pop.
- Fill the FIFO with 2 MD pushes (sel 8, sel 9) while WB is busy:
  - MdReady=0.
  - A third MdValid is held off, and the result is written only after a drain.
  - FIFO order is preserved: 8 then 9.
- Queue MD sel 10 (0x22), then WB writes sel 10 (0x33):
  - Only 0x33 is written to register 10.
  - The MD entry is popped silently, and PendingMask[10] clears the cycle after the WB grant.
- WB or MD with select 0: WriteEnable stays 0, and PendingMask[0] is never set.
- With REGFILE_ARB_STARVE_EN and STARVE_LIMIT=4, queue MD sel 12 with WbValid held high:
  - WbStall=1 for one cycle, after 4 blocked cycles.
  - The MD write to sel 12 appears on the next cycle.
  - The counter restarts at 0.
